// File: rtl/rv32i_writeback_pipe.sv
// rtl/rv32i_writeback_pipe.sv - RV32I register-file write port, destination scoreboard and read-during-write bypass.
// Optional feature: define RV32I_WB_BYPASS_EN for forwarding and accept-edge pending clear.
module rv32i_writeback_pipe #(
  parameter int XLEN     = 32,
  parameter int REG_BITS = 5
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                issue_valid_i,
  input  logic [REG_BITS-1:0] issue_rd_i,
  output logic                issue_ready_o,
  input  logic                alu_valid_i,
  input  logic [REG_BITS-1:0] alu_rd_i,
  input  logic [XLEN-1:0]     alu_data_i,
  output logic                alu_ready_o,
  input  logic                ld_valid_i,
  input  logic [REG_BITS-1:0] ld_rd_i,
  input  logic [XLEN-1:0]     ld_data_i,
  output logic                ld_ready_o,
  output logic                write_o,
  output logic [XLEN-1:0]     data_o,
  output logic [REG_BITS-1:0] rd_addr_o,
  input  logic [REG_BITS-1:0] rs1_addr_i,
  input  logic [REG_BITS-1:0] rs2_addr_i,
  output logic                rs1_busy_o,
  output logic                rs2_busy_o,
  output logic                rs1_fwd_o,
  output logic                rs2_fwd_o,
  output logic [XLEN-1:0]     rs1_fwd_data_o,
  output logic [XLEN-1:0]     rs2_fwd_data_o
);

  localparam int NREG = 1 << REG_BITS;

  logic [NREG-1:0]     pending_q, pending_d;
  logic                write_q;
  logic [XLEN-1:0]     data_q;
  logic [REG_BITS-1:0] rd_q;

  logic                ld_acc, alu_acc, acc, issue_acc, clr_en;
  logic [REG_BITS-1:0] acc_rd, clr_rd;
  logic [XLEN-1:0]     acc_data;

  assign ld_ready_o    = !reset_i;
  assign alu_ready_o   = !reset_i && !ld_valid_i;
  assign issue_ready_o = !reset_i && (issue_rd_i == '0 || !pending_q[issue_rd_i]);

  assign ld_acc    = ld_valid_i && ld_ready_o;
  assign alu_acc   = alu_valid_i && alu_ready_o;
  assign acc       = ld_acc || alu_acc;
  assign acc_rd    = ld_acc ? ld_rd_i : alu_rd_i;
  assign acc_data  = ld_acc ? ld_data_i : alu_data_i;
  assign issue_acc = issue_valid_i && issue_ready_o;

`ifdef RV32I_WB_BYPASS_EN
  assign clr_en = acc;
  assign clr_rd = acc_rd;
`else
  // Clearing only once the write lands keeps dependent reads off the colliding edge.
  assign clr_en = write_q;
  assign clr_rd = rd_q;
`endif

  // Set is applied after clear so a same-register collision leaves it pending.
  always_comb begin
    pending_d = pending_q;
    if (clr_en) pending_d[clr_rd] = 1'b0;
    if (issue_acc && issue_rd_i != '0) pending_d[issue_rd_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pending_q <= '0;
      write_q   <= 1'b0;
      data_q    <= '0;
      rd_q      <= '0;
    end else begin
      pending_q <= pending_d;
      write_q   <= acc && acc_rd != '0;
      if (acc) begin
        data_q <= acc_data;
        rd_q   <= acc_rd;
      end
    end
  end

  assign write_o    = write_q;
  assign data_o     = data_q;
  assign rd_addr_o  = rd_q;
  assign rs1_busy_o = rs1_addr_i != '0 && pending_q[rs1_addr_i];
  assign rs2_busy_o = rs2_addr_i != '0 && pending_q[rs2_addr_i];

`ifdef RV32I_WB_BYPASS_EN
  logic            fwd1_q, fwd2_q, fwd1_d, fwd2_d;
  logic [XLEN-1:0] fwd1_data_q, fwd2_data_q;

  // The BRAM returns pre-write data for a read that lands on the write edge.
  assign fwd1_d = write_q && rd_q != '0 && rs1_addr_i == rd_q;
  assign fwd2_d = write_q && rd_q != '0 && rs2_addr_i == rd_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fwd1_q      <= 1'b0;
      fwd2_q      <= 1'b0;
      fwd1_data_q <= '0;
      fwd2_data_q <= '0;
    end else begin
      fwd1_q      <= fwd1_d;
      fwd2_q      <= fwd2_d;
      fwd1_data_q <= fwd1_d ? data_q : '0;
      fwd2_data_q <= fwd2_d ? data_q : '0;
    end
  end

  assign rs1_fwd_o      = fwd1_q;
  assign rs2_fwd_o      = fwd2_q;
  assign rs1_fwd_data_o = fwd1_data_q;
  assign rs2_fwd_data_o = fwd2_data_q;
`else
  assign rs1_fwd_o      = 1'b0;
  assign rs2_fwd_o      = 1'b0;
  assign rs1_fwd_data_o = '0;
  assign rs2_fwd_data_o = '0;
`endif

endmodule

// File: tb/tb_rv32i_writeback_pipe.sv
// tb/tb_rv32i_writeback_pipe.sv - directed bench with an edge-event model of rv32i_writeback_pipe.
module tb_rv32i_writeback_pipe;
  localparam int XLEN = 32;
  localparam int RB   = 5;
  localparam int NREG = 1 << RB;

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  logic issue_valid_i = 1'b0;
  logic [RB-1:0] issue_rd_i = '0;
  logic alu_valid_i = 1'b0, ld_valid_i = 1'b0;
  logic [RB-1:0] alu_rd_i = '0, ld_rd_i = '0, rs1_addr_i = '0, rs2_addr_i = '0;
  logic [XLEN-1:0] alu_data_i = '0, ld_data_i = '0;
  logic issue_ready_o, alu_ready_o, ld_ready_o, write_o;
  logic [XLEN-1:0] data_o, rs1_fwd_data_o, rs2_fwd_data_o;
  logic [RB-1:0] rd_addr_o;
  logic rs1_busy_o, rs2_busy_o, rs1_fwd_o, rs2_fwd_o;

  always #5 clk = ~clk;

  rv32i_writeback_pipe #(.XLEN(XLEN), .REG_BITS(RB)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i), .issue_ready_o(issue_ready_o),
    .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i), .alu_ready_o(alu_ready_o),
    .ld_valid_i(ld_valid_i), .ld_rd_i(ld_rd_i), .ld_data_i(ld_data_i), .ld_ready_o(ld_ready_o),
    .write_o(write_o), .data_o(data_o), .rd_addr_o(rd_addr_o),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o),
    .rs1_fwd_o(rs1_fwd_o), .rs2_fwd_o(rs2_fwd_o),
    .rs1_fwd_data_o(rs1_fwd_data_o), .rs2_fwd_data_o(rs2_fwd_data_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic cmp(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

`ifdef RV32I_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // Model: per-register pending flag plus the edge number at which a landed write retires it.
  bit              pend[NREG];
  int              clr_at[NREG];
  int              edge_no = 0;
  bit              m_init = 1'b0;
  bit              m_wr, m_f1, m_f2;
  logic [RB-1:0]   m_rd;
  logic [XLEN-1:0] m_data, m_fd1, m_fd2;

  always @(posedge clk) begin
    bit ok_issue;
    bit take_ld, take_alu;
    logic [RB-1:0] r;
    edge_no++;
    if (reset_i) begin
      for (int i = 0; i < NREG; i++) begin pend[i] = 1'b0; clr_at[i] = -1; end
      m_wr = 0; m_rd = '0; m_data = '0;
      m_f1 = 0; m_f2 = 0; m_fd1 = '0; m_fd2 = '0;
      m_init = 1'b1;
    end else begin
      ok_issue = issue_valid_i && issue_rd_i != 0 && !pend[issue_rd_i];
      m_f1 = BYP && m_wr && rs1_addr_i == m_rd;
      m_f2 = BYP && m_wr && rs2_addr_i == m_rd;
      m_fd1 = m_f1 ? m_data : '0;
      m_fd2 = m_f2 ? m_data : '0;
      for (int i = 0; i < NREG; i++)
        if (clr_at[i] == edge_no) begin pend[i] = 1'b0; clr_at[i] = -1; end
      take_ld  = ld_valid_i;
      take_alu = alu_valid_i && !ld_valid_i;
      m_wr = 0;
      if (take_ld || take_alu) begin
        r      = take_ld ? ld_rd_i : alu_rd_i;
        m_rd   = r;
        m_data = take_ld ? ld_data_i : alu_data_i;
        m_wr   = (r != 0);
        if (BYP) pend[r] = 1'b0;
        else if (r != 0) clr_at[r] = edge_no + 1;
      end
      if (ok_issue) pend[issue_rd_i] = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      cmp("issue_ready", {31'd0, issue_ready_o},
          {31'd0, !reset_i && (issue_rd_i == 0 || !pend[issue_rd_i])});
      cmp("ld_ready", {31'd0, ld_ready_o}, {31'd0, !reset_i});
      cmp("alu_ready", {31'd0, alu_ready_o}, {31'd0, !reset_i && !ld_valid_i});
      cmp("write", {31'd0, write_o}, {31'd0, m_wr});
      cmp("data", data_o, m_data);
      cmp("rd_addr", {27'd0, rd_addr_o}, {27'd0, m_rd});
      cmp("rs1_busy", {31'd0, rs1_busy_o}, {31'd0, rs1_addr_i != 0 && pend[rs1_addr_i]});
      cmp("rs2_busy", {31'd0, rs2_busy_o}, {31'd0, rs2_addr_i != 0 && pend[rs2_addr_i]});
      cmp("rs1_fwd", {31'd0, rs1_fwd_o}, {31'd0, m_f1});
      cmp("rs2_fwd", {31'd0, rs2_fwd_o}, {31'd0, m_f2});
      cmp("rs1_fwd_data", rs1_fwd_data_o, m_fd1);
      cmp("rs2_fwd_data", rs2_fwd_data_o, m_fd2);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  task automatic issue(input logic [RB-1:0] rd);
    issue_valid_i = 1'b1; issue_rd_i = rd;
    tick();
    issue_valid_i = 1'b0;
  endtask

  initial begin
    // Reset held two cycles with an ALU result offered.
    alu_valid_i = 1'b1; alu_rd_i = 5'd1; alu_data_i = 32'hCAFE0001;
    tick(); tick();
    mid();
    cmp("lit_rst_write", {31'd0, write_o}, 32'd0);
    cmp("lit_rst_alu_ready", {31'd0, alu_ready_o}, 32'd0);
    cmp("lit_rst_ld_ready", {31'd0, ld_ready_o}, 32'd0);
    cmp("lit_rst_data", data_o, 32'd0);
    tick();
    reset_i = 1'b0; alu_valid_i = 1'b0;

    // Issue rd=5, re-issue stalls, ALU result retires it.
    issue(5'd5);
    rs1_addr_i = 5'd5;
    issue_valid_i = 1'b1; issue_rd_i = 5'd5;
    mid();
    cmp("lit_busy5", {31'd0, rs1_busy_o}, 32'd1);
    cmp("lit_reissue_stall", {31'd0, issue_ready_o}, 32'd0);
    tick();
    issue_valid_i = 1'b0;
    alu_valid_i = 1'b1; alu_rd_i = 5'd5; alu_data_i = 32'hDEADBEEF;
    tick();
    alu_valid_i = 1'b0;
    mid();
    cmp("lit_wr5", {31'd0, write_o}, 32'd1);
    cmp("lit_rd5", {27'd0, rd_addr_o}, 32'd5);
    cmp("lit_data5", data_o, 32'hDEADBEEF);
    cmp("lit_busy5_wcycle", {31'd0, rs1_busy_o}, BYP ? 32'd0 : 32'd1);
    tick();
    mid();
    cmp("lit_idle_hold", data_o, 32'hDEADBEEF);
    cmp("lit_busy5_after", {31'd0, rs1_busy_o}, 32'd0);
    tick();

    // Simultaneous load and ALU: load first.
    issue(5'd3); issue(5'd4);
    ld_valid_i = 1'b1; ld_rd_i = 5'd3; ld_data_i = 32'h11;
    alu_valid_i = 1'b1; alu_rd_i = 5'd4; alu_data_i = 32'h22;
    mid();
    cmp("lit_alu_blocked", {31'd0, alu_ready_o}, 32'd0);
    tick();
    ld_valid_i = 1'b0;
    mid();
    cmp("lit_ld_first", data_o, 32'h11);
    tick();
    alu_valid_i = 1'b0;
    mid();
    cmp("lit_alu_next", data_o, 32'h22);
    cmp("lit_alu_rd", {27'd0, rd_addr_o}, 32'd4);
    tick(); tick();
    rs1_addr_i = 5'd3; rs2_addr_i = 5'd4;
    mid();
    cmp("lit_clr3", {31'd0, rs1_busy_o}, 32'd0);
    cmp("lit_clr4", {31'd0, rs2_busy_o}, 32'd0);

    // Bypass scenario on rd=7.
    issue(5'd7);
    alu_valid_i = 1'b1; alu_rd_i = 5'd7; alu_data_i = 32'h1234;
    tick();
    alu_valid_i = 1'b0; rs1_addr_i = 5'd7; rs2_addr_i = 5'd8;
    mid();
    cmp("lit_busy7_wcycle", {31'd0, rs1_busy_o}, BYP ? 32'd0 : 32'd1);
    tick();
    mid();
    cmp("lit_fwd1", {31'd0, rs1_fwd_o}, BYP ? 32'd1 : 32'd0);
    cmp("lit_fwd1_data", rs1_fwd_data_o, BYP ? 32'h1234 : 32'd0);
    cmp("lit_fwd2", {31'd0, rs2_fwd_o}, 32'd0);
    cmp("lit_busy7_after", {31'd0, rs1_busy_o}, 32'd0);
    tick();

    // rd=0 result and issue.
    alu_valid_i = 1'b1; alu_rd_i = 5'd0; alu_data_i = 32'hFFFFFFFF;
    tick();
    alu_valid_i = 1'b0;
    mid();
    cmp("lit_rd0_nowrite", {31'd0, write_o}, 32'd0);
    issue_valid_i = 1'b1; issue_rd_i = 5'd0;
    mid();
    cmp("lit_issue0_ready", {31'd0, issue_ready_o}, 32'd1);
    tick();
    issue_valid_i = 1'b0; rs1_addr_i = 5'd0;
    mid();
    cmp("lit_busy0", {31'd0, rs1_busy_o}, 32'd0);

    // Back-to-back stream with alternating sources and live read addresses.
    for (int r = 10; r < 14; r++) issue(r[RB-1:0]);
    for (int r = 10; r < 14; r++) begin
      ld_valid_i  = r[0];  ld_rd_i  = r[RB-1:0]; ld_data_i  = 32'hA000_0000 + r;
      alu_valid_i = !r[0]; alu_rd_i = r[RB-1:0]; alu_data_i = 32'hB000_0000 + r;
      rs1_addr_i  = r[RB-1:0] - 5'd1; rs2_addr_i = r[RB-1:0];
      tick();
    end
    ld_valid_i = 1'b0; alu_valid_i = 1'b0;
    tick(); tick();

    // Reset with pending rd=9 and an ALU result waiting.
    issue(5'd9);
    alu_valid_i = 1'b1; alu_rd_i = 5'd9; alu_data_i = 32'h99;
    reset_i = 1'b1;
    tick(); tick();
    mid();
    cmp("lit_rst2_write", {31'd0, write_o}, 32'd0);
    reset_i = 1'b0; alu_valid_i = 1'b0;
    tick();
    rs1_addr_i = 5'd9;
    issue_valid_i = 1'b1; issue_rd_i = 5'd9;
    mid();
    cmp("lit_rst2_busy9", {31'd0, rs1_busy_o}, 32'd0);
    cmp("lit_rst2_issue9", {31'd0, issue_ready_o}, 32'd1);
    tick();
    issue_valid_i = 1'b0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rv32i_writeback_pipe.md
# rv32i_writeback_pipe

Write-side companion of the pipelined RV32I register file: accepts results from the ALU and load paths, drives the register file write port (write/data/rd address), and tracks in-flight destinations with a per-register scoreboard. Also provides a one-cycle bypass for the read-during-write collision of the register file's synchronous BRAM read. Sits between execute/memory stages and the register file, and feeds stall/forward signals to decode.

## Interface
- XLEN, 32, data width
- REG_BITS, 5, register address width; 2**REG_BITS scoreboard entries
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- issue_valid_i  in  1  decode wants to issue an instruction that writes issue_rd_i
- issue_rd_i  in  REG_BITS  destination of issuing instruction
- issue_ready_o  out  1  issue accepted this cycle if high with issue_valid_i
- alu_valid_i / alu_rd_i / alu_data_i  in  1/REG_BITS/XLEN  ALU result
- alu_ready_o  out  1  ALU result accepted
- ld_valid_i / ld_rd_i / ld_data_i  in  1/REG_BITS/XLEN  load result
- ld_ready_o  out  1  load result accepted
- write_o  out  1  register file write enable
- data_o  out  XLEN  register file write data
- rd_addr_o  out  REG_BITS  register file write address
- rs1_addr_i, rs2_addr_i  in  REG_BITS  read addresses presented to the register file this cycle
- rs1_busy_o, rs2_busy_o  out  1  source has a pending write; decode must stall
- rs1_fwd_o, rs2_fwd_o  out  1  register file output is stale this cycle; use fwd data
- rs1_fwd_data_o, rs2_fwd_data_o  out  XLEN  forwarded data

## Operation
- Scoreboard: 2**REG_BITS pending bits. x0 never pending.
- issue_ready_o = !reset_i && (issue_rd_i == 0 || !pending[issue_rd_i]); ignores same-cycle clears (conservative). Accept sets pending[issue_rd_i] (unless rd==0).
- Arbitration, fixed priority: ld_ready_o = !reset_i; alu_ready_o = !reset_i && !ld_valid_i. Load wins on simultaneous valid; ALU holds its result until accepted.
- Accepted result (rd, data) registered into data_o/rd_addr_o; write_o = accepted && rd != 0. A result with rd==0 is consumed and dropped.
- Idle cycle: write_o=0; data_o/rd_addr_o hold last value.
- Set and clear of different registers on the same edge both take effect. Set and clear of the same register on one edge cannot occur (issue_ready_o low); if it does, set wins.
- busy: rsN_busy_o = pending[rsN_addr_i] (combinational), 0 for address 0.
- Register file read-during-write returns old data; bypass corrects this: if at edge E write_o=1, rd_addr_o != 0 and rsN_addr_i == rd_addr_o, then in cycle after E rsN_fwd_o=1 and rsN_fwd_data_o=data_o sampled at E; otherwise rsN_fwd_o=0.
- Reset: pending all cleared, write_o=0, data_o=0, rd_addr_o=0, fwd outputs 0, fwd data 0; all ready outputs 0 while reset_i high. Results offered during reset are not accepted; in-flight writes are lost.

## Timing
- Result accepted at edge N; write_o high in cycle N+1; register file writes at edge N+1.
- Accept-to-write latency 1 cycle; throughput one result per cycle.
- Issue: pending set at accepting edge; busy visible the next cycle.
- With bypass: pending cleared at edge N (accept edge); busy low in cycle N+1; a read presented in N+1 collides at edge N+1 and is forwarded in cycle N+2.
- Without bypass: pending cleared at edge N+1; busy low from cycle N+2; reads never collide.

## Configuration
- RV32I_WB_BYPASS_EN defined: forwarding logic present, early (accept-edge) pending clear as above.
- Undefined: rsN_fwd_o and rsN_fwd_data_o tied 0; pending cleared one edge later; dependent instructions stall one extra cycle.

## Test plan
- Reset: hold reset_i 2 cycles with alu_valid_i=1 -> no write_o, all ready 0, busy 0, outputs 0.
- Issue rd=5, then ALU result rd=5 data 0xDEADBEEF -> busy(5) high until clear edge; write_o=1, rd_addr_o=5, data_o=0xDEADBEEF one cycle after accept; second issue to rd=5 stalled while pending.
- Simultaneous ld rd=3 data 0x11 and alu rd=4 data 0x22 -> load written first, alu_ready_o low that cycle, ALU written next cycle; both pending bits cleared.
- Bypass on: write rd=7 data 0x1234 with rs1_addr_i=7, rs2_addr_i=8 at write edge -> next cycle rs1_fwd_o=1, data 0x1234; rs2_fwd_o=0. Bypass off: same stimulus -> fwd 0, busy(7) held one cycle longer.
- Result with rd=0 data 0xFFFFFFFF -> accepted, write_o stays 0; issue rd=0 never sets busy.
- Reset asserted with pending rd=9 and ALU result waiting -> pending cleared, no write; after release, issue rd=9 accepted immediately.
